// File: rtl/sc_issue_pkg.sv
// sc_issue_pkg: shared constants and types for the SimpleCore issue stage.
//   SC_WORD_SIZE       default datapath width
//   sc_alu_e           ALU operation codes understood by the downstream ALU
//   OPC_* / F3_* / F7_* RV32I OP / OP-IMM encoding fields
//   dec_ctl_t          control bundle produced by the decoder
package sc_issue_pkg;

  localparam int SC_WORD_SIZE = 32;

  typedef enum logic [2:0] {
    SC_ALU_ADD = 3'd0,
    SC_ALU_SUB = 3'd1,
    SC_ALU_AND = 3'd2,
    SC_ALU_OR  = 3'd3,
    SC_ALU_XOR = 3'd4,
    SC_ALU_SLL = 3'd5,
    SC_ALU_SRL = 3'd6,
    SC_ALU_SRA = 3'd7
  } sc_alu_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    sc_alu_e op;
    logic    use_rs2;  // rs2 read by this instruction (OP only)
    logic    is_imm;   // operand b / shamt come from the instruction word
    logic    is_shift; // operand b is a 5-bit shift amount
    logic    swap_ab;  // SUB: ALU computes b-a, so rs1 goes to b
    logic    illegal;
  } dec_ctl_t;

endpackage

// File: rtl/sc_issue_decode.sv
// sc_issue_decode: purely combinational RV32I OP / OP-IMM decoder.
//   i_inst  instruction word
//   o_ctl   decoded control bundle (op, use_rs2, is_imm, is_shift, swap_ab, illegal)
//   o_imm   I-type immediate sign-extended to W bits
module sc_issue_decode
  import sc_issue_pkg::*;
#(
  parameter int W = SC_WORD_SIZE
) (
  input  logic [31:0]  i_inst,
  output dec_ctl_t     o_ctl,
  output logic [W-1:0] o_imm
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic       w_is_op;
  logic       w_is_imm;
  logic       w_bad;

  assign w_opc    = i_inst[6:0];
  assign w_f3     = i_inst[14:12];
  assign w_f7     = i_inst[31:25];
  assign w_is_op  = (w_opc == OPC_OP);
  assign w_is_imm = (w_opc == OPC_OP_IMM);
  assign o_imm    = {{(W-12){i_inst[31]}}, i_inst[31:20]};

  always_comb begin
    o_ctl         = '0;
    o_ctl.op      = SC_ALU_ADD;
    o_ctl.is_imm  = w_is_imm;
    o_ctl.use_rs2 = w_is_op;
    w_bad         = 1'b0;
    // funct7 is only an opcode extension for OP and for immediate shifts;
    // for the other OP-IMM forms those bits belong to the immediate.
    case (w_f3)
      F3_ADD: begin
        if (w_is_op && w_f7 == F7_ALT) begin
          o_ctl.op      = SC_ALU_SUB;
          o_ctl.swap_ab = 1'b1;
        end else begin
          w_bad = w_is_op && (w_f7 != F7_ZERO);
        end
      end
      F3_SLL: begin
        o_ctl.op       = SC_ALU_SLL;
        o_ctl.is_shift = 1'b1;
        w_bad          = (w_f7 != F7_ZERO);
      end
      F3_SLT, F3_SLTU: w_bad = 1'b1;
      F3_XOR: begin
        o_ctl.op = SC_ALU_XOR;
        w_bad    = w_is_op && (w_f7 != F7_ZERO);
      end
      F3_SR: begin
        o_ctl.op       = (w_f7 == F7_ALT) ? SC_ALU_SRA : SC_ALU_SRL;
        o_ctl.is_shift = 1'b1;
        w_bad          = (w_f7 != F7_ZERO) && (w_f7 != F7_ALT);
      end
      F3_OR: begin
        o_ctl.op = SC_ALU_OR;
        w_bad    = w_is_op && (w_f7 != F7_ZERO);
      end
      F3_AND: begin
        o_ctl.op = SC_ALU_AND;
        w_bad    = w_is_op && (w_f7 != F7_ZERO);
      end
    endcase
    o_ctl.illegal = ~(w_is_op | w_is_imm) | w_bad;
  end

endmodule

// File: rtl/sc_issue.sv
// sc_issue: decode/issue stage feeding the 1-cycle registered SimpleCore ALU.
//   clk, rst_n                 clock, async active-low reset
//   flush_in                   kills everything in E and W
//   inst_valid_in/inst_in      instruction handshake input, inst_ready_out back
//   rf_rs*_addr_out/_data_in   two async register-file read ports
//   alu_op/a/b_out             registered ALU inputs (E stage)
//   wb_en_out/wb_rd_out        regfile write control aligned with ALU result (W)
//   illegal_out                one-cycle pulse in the W slot of an illegal instruction
// No forwarding: a reader waits until the writer has left W.
module sc_issue
  import sc_issue_pkg::*;
#(
  parameter int WORD_SIZE = SC_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_in,
  input  logic                 inst_valid_in,
  input  logic [31:0]          inst_in,
  output logic                 inst_ready_out,
  output logic [4:0]           rf_rs1_addr_out,
  output logic [4:0]           rf_rs2_addr_out,
  input  logic [WORD_SIZE-1:0] rf_rs1_data_in,
  input  logic [WORD_SIZE-1:0] rf_rs2_data_in,
  output logic [2:0]           alu_op_out,
  output logic [WORD_SIZE-1:0] alu_a_out,
  output logic [WORD_SIZE-1:0] alu_b_out,
  output logic                 wb_en_out,
  output logic [4:0]           wb_rd_out,
  output logic                 illegal_out
);

  dec_ctl_t             w_ctl;
  logic [WORD_SIZE-1:0] w_imm;
  logic [4:0]           w_rs1, w_rs2, w_rd;
  logic                 w_haz1, w_haz2, w_accept;
  logic [WORD_SIZE-1:0] w_a, w_b;

  // E stage
  logic                 r_e_vld, r_e_wb, r_e_ill;
  logic [4:0]           r_e_rd;
  logic [2:0]           r_alu_op;
  logic [WORD_SIZE-1:0] r_alu_a, r_alu_b;
  // W stage
  logic                 r_wb_en, r_ill;
  logic [4:0]           r_wb_rd;

  sc_issue_decode #(.W(WORD_SIZE)) u_dec (
    .i_inst (inst_in),
    .o_ctl  (w_ctl),
    .o_imm  (w_imm)
  );

  assign w_rs1 = inst_in[19:15];
  assign w_rs2 = inst_in[24:20];
  assign w_rd  = inst_in[11:7];
  assign rf_rs1_addr_out = w_rs1;
  assign rf_rs2_addr_out = w_rs2;

  // r_e_wb / r_wb_en already exclude x0 and illegal slots, so they mark
  // exactly the pending writes a reader must wait for.
  assign w_haz1 = (w_rs1 != 5'd0) &&
                  ((r_e_wb && r_e_rd == w_rs1) || (r_wb_en && r_wb_rd == w_rs1));
  assign w_haz2 = w_ctl.use_rs2 && (w_rs2 != 5'd0) &&
                  ((r_e_wb && r_e_rd == w_rs2) || (r_wb_en && r_wb_rd == w_rs2));

  assign inst_ready_out = ~flush_in & ~w_haz1 & ~w_haz2;
  assign w_accept       = inst_valid_in & inst_ready_out;

  always_comb begin
    w_a = rf_rs1_data_in;
    w_b = rf_rs2_data_in;
    if (w_ctl.swap_ab) begin
      w_a = rf_rs2_data_in;
      w_b = rf_rs1_data_in;
    end else if (w_ctl.is_shift) begin
      w_b = {{(WORD_SIZE-5){1'b0}}, (w_ctl.is_imm ? inst_in[24:20] : rf_rs2_data_in[4:0])};
    end else if (w_ctl.is_imm) begin
      w_b = w_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_vld  <= 1'b0;
      r_e_wb   <= 1'b0;
      r_e_ill  <= 1'b0;
      r_e_rd   <= 5'd0;
      r_alu_op <= 3'd0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else begin
      // flush forces ready low, so accept never coincides with it
      r_e_vld <= w_accept;
      r_e_wb  <= w_accept & ~w_ctl.illegal & (w_rd != 5'd0);
      r_e_ill <= w_accept & w_ctl.illegal;
      if (w_accept) begin
        r_e_rd   <= w_rd;
        r_alu_op <= w_ctl.op;
        r_alu_a  <= w_a;
        r_alu_b  <= w_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en <= 1'b0;
      r_ill   <= 1'b0;
      r_wb_rd <= 5'd0;
    end else begin
      r_wb_en <= r_e_vld & r_e_wb & ~flush_in;
      r_ill   <= r_e_vld & r_e_ill & ~flush_in;
      if (r_e_vld) r_wb_rd <= r_e_rd;
    end
  end

  assign alu_op_out = r_alu_op;
  assign alu_a_out  = r_alu_a;
  assign alu_b_out  = r_alu_b;
  assign wb_rd_out  = r_wb_rd;
  // a flush also kills the slot currently sitting in W
  assign wb_en_out   = r_wb_en & ~flush_in;
  assign illegal_out = r_ill & ~flush_in;

endmodule
